// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared definitions for the decode/control stage.
// Holds the opcode map, ALU operation codes, halt FSM state encoding and the
// control bundle carried from ID into ID/EX.
package decode_ctrl_pipe_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SH_W     = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'h0,
        OP_ADDZ = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_NOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_LHB  = 4'hA,
        OP_LLB  = 4'hB,
        OP_B    = 4'hC,
        OP_JAL  = 4'hD,
        OP_JR   = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_LHB = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_LLB = 4'd8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Control bundle; an all-zero value is a bubble.
    typedef struct packed {
        logic [REG_W-1:0]    rdReg1;
        logic [REG_W-1:0]    rdReg2;
        logic [REG_W-1:0]    wrReg;
        logic                rdEn1;
        logic                rdEn2;
        logic                wrRaw;
        logic                isAddz;
        logic                memRd;
        logic                memWr;
        logic                mem2reg;
        logic                sawBr;
        logic                sawJ;
        logic                aluSrc;
        logic [ALU_OP_W-1:0] aluOp;
        logic [SH_W-1:0]     shAmt;
    } ctrl_t;

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// Pure combinational instruction-to-control-bundle map.
// Ports:
//   instr  in  16  raw instruction
//   ctrl   out     decoded control bundle (ctrl_t)
//   isHlt  out 1   instruction is HLT
module ctrl_decode
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int unsigned LINK_REG = 15
) (
    input  logic [15:0] instr,
    output ctrl_t       ctrl,
    output logic        isHlt
);

    logic [REG_W-1:0] fA;
    logic [REG_W-1:0] fB;
    logic [REG_W-1:0] fC;

    assign fA = instr[11:8];
    assign fB = instr[7:4];
    assign fC = instr[3:0];

    always_comb begin
        ctrl  = '0;
        isHlt = 1'b0;
        case (opcode_e'(instr[15:12]))
            OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: begin
                ctrl.rdReg1 = fB;
                ctrl.rdReg2 = fC;
                ctrl.rdEn1  = 1'b1;
                ctrl.rdEn2  = 1'b1;
                ctrl.wrReg  = fA;
                ctrl.wrRaw  = 1'b1;
                ctrl.isAddz = (opcode_e'(instr[15:12]) == OP_ADDZ);
                case (opcode_e'(instr[15:12]))
                    OP_SUB:  ctrl.aluOp = ALU_SUB;
                    OP_AND:  ctrl.aluOp = ALU_AND;
                    OP_NOR:  ctrl.aluOp = ALU_NOR;
                    default: ctrl.aluOp = ALU_ADD;
                endcase
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                ctrl.rdReg1 = fB;
                ctrl.rdEn1  = 1'b1;
                ctrl.wrReg  = fA;
                ctrl.wrRaw  = 1'b1;
                ctrl.aluSrc = 1'b1;
                ctrl.shAmt  = fC;
                case (opcode_e'(instr[15:12]))
                    OP_SRL:  ctrl.aluOp = ALU_SRL;
                    OP_SRA:  ctrl.aluOp = ALU_SRA;
                    default: ctrl.aluOp = ALU_SLL;
                endcase
            end
            OP_LW: begin
                ctrl.rdReg1  = fB;
                ctrl.rdEn1   = 1'b1;
                ctrl.wrReg   = fA;
                ctrl.wrRaw   = 1'b1;
                ctrl.memRd   = 1'b1;
                ctrl.mem2reg = 1'b1;
                ctrl.aluSrc  = 1'b1;
                ctrl.aluOp   = ALU_ADD;
            end
            OP_SW: begin
                // Base in reg1, store data in reg2.
                ctrl.rdReg1 = fB;
                ctrl.rdReg2 = fA;
                ctrl.rdEn1  = 1'b1;
                ctrl.rdEn2  = 1'b1;
                ctrl.memWr  = 1'b1;
                ctrl.aluSrc = 1'b1;
                ctrl.aluOp  = ALU_ADD;
            end
            OP_LHB, OP_LLB: begin
                // Byte loads merge into the existing destination value.
                ctrl.rdReg1 = fA;
                ctrl.rdEn1  = 1'b1;
                ctrl.wrReg  = fA;
                ctrl.wrRaw  = 1'b1;
                ctrl.aluSrc = 1'b1;
                ctrl.aluOp  = (opcode_e'(instr[15:12]) == OP_LHB) ? ALU_LHB : ALU_LLB;
            end
            OP_B: begin
                ctrl.sawBr = 1'b1;
            end
            OP_JAL: begin
                ctrl.wrReg = REG_W'(LINK_REG);
                ctrl.wrRaw = 1'b1;
                ctrl.sawJ  = 1'b1;
            end
            OP_JR: begin
                ctrl.rdReg1 = fB;
                ctrl.rdEn1  = 1'b1;
                ctrl.sawJ   = 1'b1;
            end
            OP_HLT: begin
                isHlt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode/control stage: decodes IF/ID into the ID/EX control
// register, stalls fetch on load-use hazards, inserts bubbles on flush, and
// drains the pipe before asserting halted.
// Ports:
//   clk, rst              clock, async active-high reset
//   id_instr, id_vld      instruction in IF/ID and its valid
//   ex_flush              kill ID (branch/jump resolved in EX)
//   ex_z                  Z flag seen by the instruction in EX
//   id_stall              hold PC and IF/ID (combinational)
//   ex_*                  ID/EX control fields; ex_wr_en qualified in EX
//   halted                sticky halt indication
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter int unsigned LINK_REG       = 15,
    parameter int unsigned R0_WR_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_vld,
    input  logic        ex_flush,
    input  logic        ex_z,
    output logic        id_stall,
    output logic        ex_vld,
    output logic [3:0]  ex_rd_reg1,
    output logic [3:0]  ex_rd_reg2,
    output logic [3:0]  ex_wr_reg,
    output logic        ex_rd_en1,
    output logic        ex_rd_en2,
    output logic        ex_wr_en,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_mem2reg,
    output logic        ex_saw_br,
    output logic        ex_saw_j,
    output logic        ex_alu_src,
    output logic [3:0]  ex_alu_op,
    output logic [3:0]  ex_sh_amt,
    output logic        halted
);

    // DRAIN_CYCLES must be at least 1.
    localparam int unsigned     CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic            R0_SUP   = (R0_WR_SUPPRESS != 0);

    ctrl_t            idCtrl;
    ctrl_t            exCtrl;
    ctrl_t            nxtCtrl;
    logic             idIsHlt;
    logic             exVldQ;
    logic             issue;
    logic             hazard;
    state_e           state;
    state_e           nxtState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxtCnt;

    ctrl_decode #(
        .LINK_REG(LINK_REG)
    ) uDecode (
        .instr(id_instr),
        .ctrl (idCtrl),
        .isHlt(idIsHlt)
    );

    // Load-use: LW to a non-zero register sitting in EX feeds an ID source.
    always_comb begin
        hazard = exVldQ & exCtrl.memRd & (exCtrl.wrReg != '0) & id_vld &
                 ((idCtrl.rdEn1 & (idCtrl.rdReg1 == exCtrl.wrReg)) |
                  (idCtrl.rdEn2 & (idCtrl.rdReg2 == exCtrl.wrReg)));
    end

    // Halt FSM state and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= nxtState;
            cnt   <= nxtCnt;
        end
    end

    // Next-state: a committed HLT starts the drain; flush no longer matters once draining.
    always_comb begin
        nxtState = state;
        nxtCnt   = cnt;
        case (state)
            ST_RUN: begin
                if (id_vld && idIsHlt && !ex_flush) begin
                    nxtState = ST_DRAIN;
                    nxtCnt   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    nxtState = ST_HALT;
                end else begin
                    nxtCnt = cnt - CNT_W'(1);
                end
            end
            ST_HALT:  nxtState = ST_HALT;
            default:  nxtState = ST_RUN;
        endcase
    end

    // Outputs: flush beats stall; HLT itself issues as a bubble.
    always_comb begin
        id_stall = 1'b0;
        issue    = 1'b0;
        case (state)
            ST_RUN: begin
                id_stall = hazard & ~ex_flush;
                issue    = id_vld & ~ex_flush & ~hazard & ~idIsHlt;
            end
            default: begin
                id_stall = 1'b1;
            end
        endcase
        nxtCtrl = issue ? idCtrl : '0;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exCtrl <= '0;
            exVldQ <= 1'b0;
        end else begin
            exCtrl <= nxtCtrl;
            exVldQ <= issue;
        end
    end

    assign ex_vld     = exVldQ;
    assign ex_rd_reg1 = exCtrl.rdReg1;
    assign ex_rd_reg2 = exCtrl.rdReg2;
    assign ex_wr_reg  = exCtrl.wrReg;
    assign ex_rd_en1  = exCtrl.rdEn1;
    assign ex_rd_en2  = exCtrl.rdEn2;
    assign ex_mem_rd  = exCtrl.memRd;
    assign ex_mem_wr  = exCtrl.memWr;
    assign ex_mem2reg = exCtrl.mem2reg;
    assign ex_saw_br  = exCtrl.sawBr;
    assign ex_saw_j   = exCtrl.sawJ;
    assign ex_alu_src = exCtrl.aluSrc;
    assign ex_alu_op  = exCtrl.aluOp;
    assign ex_sh_amt  = exCtrl.shAmt;
    assign halted     = (state == ST_HALT);

    // ADDZ commits only if Z is set when it reaches EX.
    assign ex_wr_en = exCtrl.wrRaw & (~exCtrl.isAddz | ex_z) &
                      ~(R0_SUP & (exCtrl.wrReg == '0)) & exVldQ;

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered decode/control stage for the 16-bit pipelined core. Decodes the IF/ID instruction into the full control bundle and registers it into ID/EX. Detects load-use hazards and stalls fetch, inserts bubbles on branch/jump flush, and sequences halt by draining the pipe. ADDZ write-enable is resolved in EX against the live Z flag, not at decode.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles between HLT leaving ID and `halted` asserting (EX, MEM, WB drain).
- LINK_REG, 15: destination register for JAL.
- R0_WR_SUPPRESS, 1: when 1, any write to R0 gets `ex_wr_en`=0.

Ports (reset is asynchronous and active-high; single clock):
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_instr  in  16  instruction in IF/ID.
- id_vld  in  1  `id_instr` is valid.
- ex_flush  in  1  branch taken or jump resolved in EX; kill ID.
- ex_z  in  1  Z flag visible to the instruction currently in EX.
- id_stall  out  1  hold PC and IF/ID this cycle.
- ex_vld  out  1  ID/EX holds a real instruction.
- ex_rd_reg1, ex_rd_reg2, ex_wr_reg  out  4 each  register fields.
- ex_rd_en1, ex_rd_en2  out  1 each  read enables.
- ex_wr_en  out  1  final write enable (ADDZ already qualified by `ex_z`).
- ex_mem_rd, ex_mem_wr, ex_mem2reg, ex_saw_br, ex_saw_j, ex_alu_src  out  1 each.
- ex_alu_op, ex_sh_amt  out  4 each.
- halted  out  1  core halted; sticky until reset.

## Operation
- Decode table is the standard ISA control map: ADD, ADDZ, SUB, AND, NOR, SLL, SRA, SRL, LHB, LLB, LW, SW, B, JAL, JR, HLT.
  - JAL writes LINK_REG.
  - SW, B, JR and HLT have no write.
- `ex_wr_en` is combinational from the registered `wr_raw` and `is_addz` bits: `wr_raw & (~is_addz | ex_z) & ~(R0_WR_SUPPRESS & wr_reg==0) & ex_vld`.
- Load-use hazard. All three must hold:
  - ID/EX holds a valid LW with `wr_reg`≠0;
  - the decoded ID instruction has `rd_en1` and `rd_reg1`==that reg, or `rd_en2` and `rd_reg2`==that reg;
  - `id_vld`=1.
  - Response: `id_stall`=1 and a bubble (`ex_vld`=0, all enables 0) is loaded into ID/EX. Exactly one stall cycle per hazard.
- Flush: `ex_flush`=1 loads a bubble regardless of hazard and forces `id_stall`=0. Flush has priority over stall.
- FSM states RUN, DRAIN, HALT:
  - RUN -> DRAIN when a valid, unflushed HLT is in ID. The HLT itself enters ID/EX as a bubble (no enables). A down-counter loads DRAIN_CYCLES-1.
  - DRAIN: `id_stall`=1 and only bubbles are issued. The counter decrements each cycle; at 0 go to HALT. A flush arriving during DRAIN is ignored (the HLT already committed).
  - HALT: `halted`=1, `id_stall`=1, bubbles only. Only reset leaves this state.
- HLT flushed in the same cycle it sits in ID: no halt, stay in RUN.

## Timing
- Decode-to-output latency is 1 cycle: ID/EX updates on the rising edge after the instruction appears with `id_stall`=0.
- `id_stall` is combinational from the current ID contents, ID/EX state and FSM state.
- Reset values:
  - FSM=RUN, counter=0;
  - `ex_vld`=0, all ID/EX fields and enables 0;
  - `halted`=0, `id_stall`=0.
- Reset mid-DRAIN or in HALT returns to RUN immediately.
- With DRAIN_CYCLES=3, `halted` rises exactly 3 cycles after the edge that captured the HLT bubble.
- `id_vld`=0 loads a bubble with no stall.

## Structure
- Shared defines: opcode constants, ALU op constants, FSM state encoding, and the control-bundle field widths.
- One natural sub-module: `ctrl_decode`, the pure combinational instruction-to-bundle map. This module wraps it with the ID/EX register, hazard unit and halt FSM.

## Test plan
- Back-to-back independent ALU ops (ADD R1,R2,R3 then SUB R4,R5,R6) -> `ex_vld`=1 on consecutive cycles, never `id_stall`.
- LW R3 then ADD R4,R3,R5 -> `id_stall`=1 for exactly 1 cycle, one bubble; ADD issues on the following cycle.
- LW R0 then ADD R4,R0,R5 -> no stall. A write to R0 gives `ex_wr_en`=0.
- ADDZ R2,R3,R4 in EX:
  - `ex_z`=0 -> `ex_wr_en`=0;
  - `ex_z`=1 -> `ex_wr_en`=1 and `ex_wr_reg`=2.
- Hazard and `ex_flush` in the same cycle -> bubble, `id_stall`=0. HLT flushed in ID -> no halt.
- HLT in ID:
  - `halted`=1 exactly 3 cycles later, `id_stall` held high throughout;
  - `rst` pulse mid-DRAIN -> RUN, all outputs 0.
